// File: rtl/noc_endpoint.sv
// noc_endpoint: spike-packet NoC endpoint with a TX queue toward the link and an RX FSM toward the core
// Ports:
//   clk, reset                        clock and synchronous active-high reset
//   tx_valid/tx_ready/tx_n_addr/tx_data     core -> endpoint packet offer
//   link_full/link_write_en/link_n_addr_out/link_data_out  endpoint -> link FIFO push
//   link_empty/link_read_en/link_n_addr_in/link_data_in    link FIFO -> endpoint pop (data one cycle later)
//   rx_valid/rx_ready/rx_n_addr/rx_data     endpoint -> core packet delivery
//   tx_count, rx_count                packets pushed to link / delivered to core, modulo 2^16
module noc_endpoint #(
    parameter int TX_DEPTH = 4,
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [ADDR_W-1:0] tx_n_addr,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              link_full,
    output logic              link_write_en,
    output logic [ADDR_W-1:0] link_n_addr_out,
    output logic [DATA_W-1:0] link_data_out,
    input  logic              link_empty,
    output logic              link_read_en,
    input  logic [ADDR_W-1:0] link_n_addr_in,
    input  logic [DATA_W-1:0] link_data_in,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic [ADDR_W-1:0] rx_n_addr,
    output logic [DATA_W-1:0] rx_data,
    output logic [15:0]       tx_count,
    output logic [15:0]       rx_count
);
    localparam int PW = (TX_DEPTH > 1) ? $clog2(TX_DEPTH) : 1;
    localparam int EW = ADDR_W + DATA_W;
    localparam logic [PW:0] FULL = (PW+1)'(TX_DEPTH);

    typedef enum logic [1:0] {RX_IDLE, RX_WAIT, RX_HOLD} rx_state_e;

    logic [EW-1:0]     mem_q [TX_DEPTH];
    logic [PW-1:0]     wr_q, rd_q;
    logic [PW:0]       cnt_q, cnt_d;
    logic [15:0]       tx_count_q, rx_count_q;
    rx_state_e         state_q, state_d;
    logic [ADDR_W-1:0] rx_addr_q, rx_addr_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              read_en, hold, push, pop, rx_done;

    assign tx_ready      = (cnt_q != FULL) && !reset;
    assign link_write_en = (cnt_q != '0) && !link_full && !reset;
    assign push          = tx_valid && tx_ready;
    assign pop           = link_write_en;
    assign cnt_d         = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
    assign {link_n_addr_out, link_data_out} = (cnt_q != '0) ? mem_q[rd_q] : '0;

    // Power-of-two depth lets the pointers wrap naturally at TX_DEPTH-1 -> 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q       <= '0;
            rd_q       <= '0;
            cnt_q      <= '0;
            tx_count_q <= '0;
        end else begin
            wr_q       <= wr_q + PW'(push);
            rd_q       <= rd_q + PW'(pop);
            cnt_q      <= cnt_d;
            tx_count_q <= tx_count_q + 16'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= {tx_n_addr, tx_data};
    end

    always_comb begin
        state_d   = state_q;
        rx_addr_d = rx_addr_q;
        rx_data_d = rx_data_q;
        read_en   = 1'b0;
        hold      = 1'b0;
        case (state_q)
            RX_IDLE: begin
                read_en = !link_empty;
                state_d = link_empty ? RX_IDLE : RX_WAIT;
            end
            RX_WAIT: begin
                rx_addr_d = link_n_addr_in;
                rx_data_d = link_data_in;
                state_d   = RX_HOLD;
            end
            RX_HOLD: begin
                hold    = 1'b1;
                state_d = rx_ready ? RX_IDLE : RX_HOLD;
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign rx_done      = hold && rx_ready;
    assign link_read_en = read_en && !reset;
    assign rx_valid     = hold && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= RX_IDLE;
            rx_addr_q  <= '0;
            rx_data_q  <= '0;
            rx_count_q <= '0;
        end else begin
            state_q    <= state_d;
            rx_addr_q  <= rx_addr_d;
            rx_data_q  <= rx_data_d;
            rx_count_q <= rx_count_q + 16'(rx_done);
        end
    end

    assign rx_n_addr = rx_addr_q;
    assign rx_data   = rx_data_q;
    assign tx_count  = tx_count_q;
    assign rx_count  = rx_count_q;
endmodule

// File: tb/tb_noc_endpoint.sv
// tb_noc_endpoint: directed self-checking bench for noc_endpoint
module tb_noc_endpoint;
    logic        clk = 1'b0;
    logic        reset, tx_valid, tx_ready, link_full, link_write_en, link_empty, link_read_en;
    logic        rx_valid, rx_ready;
    logic [1:0]  tx_n_addr, link_n_addr_out, link_n_addr_in, rx_n_addr;
    logic [31:0] tx_data, link_data_out, link_data_in, rx_data;
    logic [15:0] tx_count, rx_count;
    int checks = 0;
    int failures = 0;

    noc_endpoint #(.TX_DEPTH(4), .DATA_W(32), .ADDR_W(2)) dut (
        .clk(clk), .reset(reset),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_n_addr(tx_n_addr), .tx_data(tx_data),
        .link_full(link_full), .link_write_en(link_write_en),
        .link_n_addr_out(link_n_addr_out), .link_data_out(link_data_out),
        .link_empty(link_empty), .link_read_en(link_read_en),
        .link_n_addr_in(link_n_addr_in), .link_data_in(link_data_in),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_n_addr(rx_n_addr), .rx_data(rx_data),
        .tx_count(tx_count), .rx_count(rx_count)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; tx_valid = 1'b0; tx_n_addr = '0; tx_data = '0;
        link_full = 1'b0; link_empty = 1'b0; link_n_addr_in = '0; link_data_in = '0; rx_ready = 1'b0;
        tick(); tick(); #1;
        checks++; if (tx_ready !== 1'b0) begin failures++; $display("FAIL reset_tx_ready got=%0h exp=0", tx_ready); end
        checks++; if (link_read_en !== 1'b0) begin failures++; $display("FAIL reset_read_en got=%0h exp=0", link_read_en); end
        checks++; if (link_write_en !== 1'b0) begin failures++; $display("FAIL reset_write_en got=%0h exp=0", link_write_en); end
        checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL reset_rx_valid got=%0h exp=0", rx_valid); end
        checks++; if (tx_count !== 16'd0 || rx_count !== 16'd0) begin failures++; $display("FAIL reset_counts got=%0h/%0h exp=0/0", tx_count, rx_count); end
        checks++; if (rx_data !== 32'd0 || rx_n_addr !== 2'd0) begin failures++; $display("FAIL reset_rx_regs got=%0h/%0h exp=0/0", rx_n_addr, rx_data); end
        reset = 1'b0; link_empty = 1'b1; #1;
        checks++; if (tx_ready !== 1'b1) begin failures++; $display("FAIL post_reset_tx_ready got=%0h exp=1", tx_ready); end
        checks++; if (link_data_out !== 32'd0) begin failures++; $display("FAIL empty_head_zero got=%0h exp=0", link_data_out); end
        tick();
    endtask

    task automatic test_fill_drain;
        link_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tx_valid = 1'b1; tx_data = 32'hA0 + 32'(i); tx_n_addr = 2'(i); #1;
            checks++; if (tx_ready !== 1'(i < 4)) begin failures++; $display("FAIL fill_tx_ready[%0d] got=%0h exp=%0h", i, tx_ready, i < 4); end
            checks++; if (link_write_en !== 1'b0) begin failures++; $display("FAIL fill_write_en[%0d] got=%0h exp=0", i, link_write_en); end
            tick();
        end
        tx_valid = 1'b0; link_full = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (link_write_en !== 1'b1) begin failures++; $display("FAIL drain_write_en[%0d] got=%0h exp=1", i, link_write_en); end
            checks++; if (link_data_out !== 32'hA0 + 32'(i) || link_n_addr_out !== 2'(i)) begin
                failures++; $display("FAIL drain_data[%0d] got=%0h/%0h exp=%0h/%0h", i, link_n_addr_out, link_data_out, 2'(i), 32'hA0 + 32'(i));
            end
            tick();
        end
        #1;
        checks++; if (link_write_en !== 1'b0) begin failures++; $display("FAIL drain_done_write_en got=%0h exp=0", link_write_en); end
        checks++; if (link_data_out !== 32'd0) begin failures++; $display("FAIL drain_done_head got=%0h exp=0", link_data_out); end
        checks++; if (tx_count !== 16'd4) begin failures++; $display("FAIL drain_tx_count got=%0d exp=4", tx_count); end
    endtask

    task automatic test_push_pop;
        link_full = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tx_valid = 1'b1; tx_data = 32'hB0 + 32'(i); tx_n_addr = 2'(i);
            tick();
        end
        link_full = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tx_data = 32'hB2 + 32'(i); tx_n_addr = 2'(i + 2); #1;
            checks++; if (link_write_en !== 1'b1 || tx_ready !== 1'b1) begin failures++; $display("FAIL pp_handshake[%0d] got=%0h/%0h exp=1/1", i, link_write_en, tx_ready); end
            checks++; if (link_data_out !== 32'hB0 + 32'(i) || link_n_addr_out !== 2'(i)) begin
                failures++; $display("FAIL pp_order[%0d] got=%0h/%0h exp=%0h/%0h", i, link_n_addr_out, link_data_out, 2'(i), 32'hB0 + 32'(i));
            end
            tick();
        end
        tx_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (link_write_en !== 1'b1 || link_data_out !== 32'hB8 + 32'(i)) begin
                failures++; $display("FAIL pp_tail[%0d] got=%0h/%0h exp=1/%0h", i, link_write_en, link_data_out, 32'hB8 + 32'(i));
            end
            tick();
        end
        #1;
        checks++; if (link_write_en !== 1'b0) begin failures++; $display("FAIL pp_empty got=%0h exp=0", link_write_en); end
        checks++; if (tx_count !== 16'd14) begin failures++; $display("FAIL pp_tx_count got=%0d exp=14", tx_count); end
    endtask

    task automatic test_rx;
        rx_ready = 1'b0; link_empty = 1'b0; #1;
        checks++; if (link_read_en !== 1'b1) begin failures++; $display("FAIL rx_read_en got=%0h exp=1", link_read_en); end
        tick();
        link_empty = 1'b1; link_data_in = 32'h1234_5678; link_n_addr_in = 2'b10; #1;
        checks++; if (link_read_en !== 1'b0 || rx_valid !== 1'b0) begin failures++; $display("FAIL rx_wait got=%0h/%0h exp=0/0", link_read_en, rx_valid); end
        tick();
        link_data_in = 32'hDEAD_BEEF; link_n_addr_in = 2'b01; link_empty = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (rx_valid !== 1'b1 || rx_data !== 32'h1234_5678 || rx_n_addr !== 2'b10) begin
                failures++; $display("FAIL rx_hold[%0d] got=%0h/%0h/%0h exp=1/2/12345678", i, rx_valid, rx_n_addr, rx_data);
            end
            checks++; if (link_read_en !== 1'b0) begin failures++; $display("FAIL rx_hold_read_en[%0d] got=%0h exp=0", i, link_read_en); end
            tick();
        end
        rx_ready = 1'b1; link_empty = 1'b1;
        tick();
        checks++; if (rx_valid !== 1'b0 || rx_count !== 16'd1) begin failures++; $display("FAIL rx_consume got=%0h/%0d exp=0/1", rx_valid, rx_count); end
    endtask

    task automatic test_back_to_back;
        rx_ready = 1'b1; link_empty = 1'b0;
        for (int c = 0; c < 30; c++) begin
            link_data_in = 32'hC000_0000 + 32'(c); link_n_addr_in = 2'(c); #1;
            checks++; if (link_read_en !== 1'(c % 3 == 0)) begin failures++; $display("FAIL b2b_read_en[%0d] got=%0h exp=%0h", c, link_read_en, c % 3 == 0); end
            checks++; if (rx_valid !== 1'(c % 3 == 2)) begin failures++; $display("FAIL b2b_rx_valid[%0d] got=%0h exp=%0h", c, rx_valid, c % 3 == 2); end
            if (c % 3 == 2) begin
                checks++; if (rx_data !== 32'hC000_0000 + 32'(c - 1)) begin failures++; $display("FAIL b2b_rx_data[%0d] got=%0h exp=%0h", c, rx_data, 32'hC000_0000 + 32'(c - 1)); end
            end
            tick();
        end
        link_empty = 1'b1; rx_ready = 1'b0; #1;
        checks++; if (rx_count !== 16'd11) begin failures++; $display("FAIL b2b_rx_count got=%0d exp=11", rx_count); end
    endtask

    task automatic test_reset_mid;
        link_full = 1'b1; link_empty = 1'b0; rx_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tx_valid = 1'b1; tx_data = 32'hD0 + 32'(i); tx_n_addr = 2'(i);
            if (i == 1) link_empty = 1'b1;
            tick();
        end
        tx_valid = 1'b0; #1;
        checks++; if (rx_valid !== 1'b1) begin failures++; $display("FAIL mid_pre_hold got=%0h exp=1", rx_valid); end
        reset = 1'b1; link_full = 1'b0; #1;
        checks++; if (link_write_en !== 1'b0 || tx_ready !== 1'b0 || rx_valid !== 1'b0) begin
            failures++; $display("FAIL mid_in_reset got=%0h/%0h/%0h exp=0/0/0", link_write_en, tx_ready, rx_valid);
        end
        tick();
        reset = 1'b0; #1;
        checks++; if (rx_valid !== 1'b0 || link_write_en !== 1'b0 || tx_ready !== 1'b1) begin
            failures++; $display("FAIL mid_after got=%0h/%0h/%0h exp=0/0/1", rx_valid, link_write_en, tx_ready);
        end
        checks++; if (tx_count !== 16'd0 || rx_count !== 16'd0) begin failures++; $display("FAIL mid_counts got=%0d/%0d exp=0/0", tx_count, rx_count); end
        checks++; if (link_read_en !== 1'b0 || link_data_out !== 32'd0) begin failures++; $display("FAIL mid_idle got=%0h/%0h exp=0/0", link_read_en, link_data_out); end
        tick();
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_push_pop();
        test_rx();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
